// File: rtl/sfx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sfx_pkg: shared types and constants for the sound-effect scheduler.
//   sfx_state_t  : scheduler FSM states (IDLE, MUSIC, PLAY, GAP)
//   SFX_SHOT..SFX_MARCH : requester indices (0 = highest priority)
//   SFX_N_REQ, SFX_PERIOD_W, SFX_DUR_W : default geometry
// ---------------------------------------------------------------------------
package sfx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUSIC = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } sfx_state_t;

  localparam int SFX_SHOT     = 0;
  localparam int SFX_HIT      = 1;
  localparam int SFX_DEATH    = 2;
  localparam int SFX_MARCH    = 3;

  localparam int SFX_N_REQ    = 4;
  localparam int SFX_PERIOD_W = 18;
  localparam int SFX_DUR_W    = 12;

endpackage

// File: rtl/sfx_scheduler_if.sv
// ---------------------------------------------------------------------------
// sfx_scheduler_if: request/tone bus between game logic and the scheduler.
//   master (game logic side): drives sfx_req, sfx_period, sfx_dur,
//                             music_en, music_period
//   slave  (scheduler side) : drives sfx_grant, sfx_active, tone_period,
//                             tone_en, tone_load
// ---------------------------------------------------------------------------
interface sfx_scheduler_if #(
  parameter int N_REQ    = 4,
  parameter int PERIOD_W = 18,
  parameter int DUR_W    = 12
);

  logic [N_REQ-1:0]          sfx_req;
  logic [N_REQ*PERIOD_W-1:0] sfx_period;
  logic [N_REQ*DUR_W-1:0]    sfx_dur;
  logic                      music_en;
  logic [PERIOD_W-1:0]       music_period;

  logic [N_REQ-1:0]          sfx_grant;
  logic [N_REQ-1:0]          sfx_active;
  logic [PERIOD_W-1:0]       tone_period;
  logic                      tone_en;
  logic                      tone_load;

  modport master (
    output sfx_req, sfx_period, sfx_dur, music_en, music_period,
    input  sfx_grant, sfx_active, tone_period, tone_en, tone_load
  );

  modport slave (
    input  sfx_req, sfx_period, sfx_dur, music_en, music_period,
    output sfx_grant, sfx_active, tone_period, tone_en, tone_load
  );

endinterface

// File: rtl/sfx_tick_gen.sv
// ---------------------------------------------------------------------------
// sfx_tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks.
//   clk   in  system clock
//   reset in  asynchronous active-high reset (counter to 0)
//   tick  out high for one cycle every TICK_DIV cycles
// ---------------------------------------------------------------------------
module sfx_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_s;

  assign wrap_s = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick   = wrap_s;

  // next prescaler value: wrap to zero on the last count
  always_comb begin
    if (wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // prescaler register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// ---------------------------------------------------------------------------
// sfx_scheduler: shares one tone generator between prioritised sound effects
// and a background music tone.
//   clk, reset : 50 MHz clock, asynchronous active-high reset
//   bus (slave): sfx_req/sfx_period/sfx_dur/music_en/music_period in,
//                sfx_grant/sfx_active/tone_period/tone_en/tone_load out
// Build option: define SFX_PREEMPT_EN to let a higher-priority request cut
// the playing effect short (no gap, the preempted effect is dropped).
// ---------------------------------------------------------------------------
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int N_REQ     = SFX_N_REQ,
  parameter int PERIOD_W  = SFX_PERIOD_W,
  parameter int DUR_W     = SFX_DUR_W,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  sfx_scheduler_if.slave    bus
);

`ifdef SFX_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  sfx_state_t          state_q;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic [IDX_W-1:0]    cur_q;
  logic [DUR_W-1:0]    remaining_q;
  logic [GAP_W-1:0]    gap_q;
  logic [N_REQ-1:0]    grant_q, active_q;
  logic [PERIOD_W-1:0] tone_period_q;
  logic                tone_en_q, tone_load_q;

  logic                tick_s, any_pend_s, grant_ok_s, gap_last_s, music_start_s;
  logic [IDX_W-1:0]    pri_idx_s, grant_idx_s;
  logic [N_REQ-1:0]    grant_oh_s;
  logic [PERIOD_W-1:0] period_sel_s;
  logic [DUR_W-1:0]    dur_sel_s;

  sfx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign bus.sfx_grant   = grant_q;
  assign bus.sfx_active  = active_q;
  assign bus.tone_period = tone_period_q;
  assign bus.tone_en     = tone_en_q;
  assign bus.tone_load   = tone_load_q;

  // priority encoder, grant selection and pending-register next state
  always_comb begin
    pri_idx_s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pri_idx_s = IDX_W'(i);
      end
    end
    any_pend_s  = |pending_q;
    gap_last_s  = (gap_q <= GAP_W'(1));
    grant_ok_s  = 1'b0;
    grant_idx_s = pri_idx_s;
    case (state_q)
      IDLE, MUSIC: grant_ok_s = any_pend_s;
      // the last gap tick doubles as the IDLE decision cycle
      GAP:         grant_ok_s = tick_s && gap_last_s && any_pend_s;
      PLAY: begin
        if (PREEMPT && any_pend_s && (pri_idx_s < cur_q)) begin
          grant_ok_s = 1'b1;
        end else if (pending_q[cur_q]) begin
          grant_ok_s  = 1'b1;
          grant_idx_s = cur_q;
        end else begin
          grant_ok_s = 1'b0;
        end
      end
      default:     grant_ok_s = 1'b0;
    endcase
    grant_oh_s    = N_REQ'(1) << grant_idx_s;
    period_sel_s  = bus.sfx_period[int'(grant_idx_s) * PERIOD_W +: PERIOD_W];
    dur_sel_s     = bus.sfx_dur[int'(grant_idx_s) * DUR_W +: DUR_W];
    music_start_s = !grant_ok_s && bus.music_en &&
                    ((state_q == IDLE) || ((state_q == GAP) && tick_s && gap_last_s));
    if (grant_ok_s) begin
      pending_d = (pending_q | bus.sfx_req) & ~grant_oh_s;
    end else begin
      pending_d = pending_q | bus.sfx_req;
    end
  end

  // scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      cur_q         <= '0;
      remaining_q   <= '0;
      gap_q         <= '0;
      grant_q       <= '0;
      active_q      <= '0;
      tone_period_q <= '0;
      tone_en_q     <= 1'b0;
      tone_load_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      grant_q     <= grant_ok_s ? grant_oh_s : '0;
      tone_load_q <= 1'b0;
      if (grant_ok_s && (dur_sel_s != '0)) begin
        state_q       <= PLAY;
        cur_q         <= grant_idx_s;
        remaining_q   <= dur_sel_s;
        tone_period_q <= period_sel_s;
        tone_load_q   <= 1'b1;
        tone_en_q     <= 1'b1;
        active_q      <= grant_oh_s;
      end else if (music_start_s) begin
        state_q       <= MUSIC;
        tone_en_q     <= 1'b1;
        tone_period_q <= bus.music_period;
        tone_load_q   <= (bus.music_period != tone_period_q);
      end else begin
        // zero-duration grants also land here: pulse only, state kept
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          MUSIC: begin
            if (!bus.music_en) begin
              state_q   <= IDLE;
              tone_en_q <= 1'b0;
            end else begin
              // tone_period_q is the registered copy of music_period
              tone_period_q <= bus.music_period;
              tone_load_q   <= (bus.music_period != tone_period_q);
            end
          end
          PLAY: begin
            if (tick_s) begin
              if (remaining_q == DUR_W'(1)) begin
                active_q  <= '0;
                tone_en_q <= 1'b0;
                if (GAP_TICKS != 0) begin
                  state_q <= GAP;
                  gap_q   <= GAP_W'(GAP_TICKS);
                end else begin
                  state_q <= IDLE;
                end
              end else begin
                remaining_q <= remaining_q - DUR_W'(1);
              end
            end
          end
          GAP: begin
            if (tick_s) begin
              if (gap_last_s) begin
                state_q <= IDLE;
              end else begin
                gap_q <= gap_q - GAP_W'(1);
              end
            end
          end
          default: begin
            state_q   <= IDLE;
            tone_en_q <= 1'b0;
            active_q  <= '0;
          end
        endcase
      end
    end
  end

endmodule
